// File: rtl/addr_bus_sequencer_if.sv
// Address-bus arbitration bundle: requester-side request/write lines and the
// grant, select, memory strobe and completion lines returned by the sequencer.
interface addr_bus_sequencer_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] wr;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] sel;
  logic [NREQ-1:0] done;
  logic            mem_rd;
  logic            mem_wr;
  logic            busy;

  // master = requesters / instruction sequencer, slave = bus sequencer
  modport master (output req, wr, input gnt, sel, done, mem_rd, mem_wr, busy);
  modport slave  (input req, wr, output gnt, sel, done, mem_rd, mem_wr, busy);
endinterface

// File: rtl/addr_bus_sequencer.sv
// Round-robin owner of the shared address bus: grant, settle select, strobe
// memory, then release with a one-cycle done pulse to the winner.
module addr_bus_sequencer #(
  parameter int NREQ   = 4,
  parameter int SETTLE = 3,
  parameter int HOLD   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  addr_bus_sequencer_if.slave  bus
);
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CMAX = (SETTLE > HOLD) ? SETTLE : HOLD;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX + 1) : 1;

  typedef enum logic [1:0] {IDLE, SELECT, STROBE, RELEASE} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d, idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wr_q, wr_d;
  logic [NREQ-1:0] gnt_q, gnt_d, sel_q, sel_d, done_q, done_d;
  logic            rd_q, rd_d, mwr_q, mwr_d;
  logic            found;
  logic [PW-1:0]   win;
  logic [NREQ-1:0] oh;

  // Round-robin search upward from ptr, first requester wins.
  always_comb begin : arb
    int j;
    j     = 0;
    found = 1'b0;
    win   = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr_q) + k) % NREQ;
      if (!found && bus.req[j]) begin
        found = 1'b1;
        win   = PW'(j);
      end
    end
  end

  always_comb begin : fsm
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    case (state_q)
      IDLE: if (found) begin
        idx_d   = win;
        wr_d    = bus.wr[win];
        ptr_d   = (int'(win) == NREQ - 1) ? '0 : win + PW'(1);
        cnt_d   = CW'(SETTLE - 1);
        state_d = SELECT;
      end
      SELECT: if (cnt_q == '0) begin
        cnt_d   = CW'(HOLD - 1);
        state_d = STROBE;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
      STROBE: if (cnt_q == '0) state_d = RELEASE;
              else             cnt_d   = cnt_q - CW'(1);
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they come straight off flops.
    oh     = NREQ'(1) << idx_d;
    gnt_d  = (state_d != IDLE)    ? oh : '0;
    sel_d  = gnt_d;
    done_d = (state_d == RELEASE) ? oh : '0;
    rd_d   = (state_d == STROBE) && !wr_d;
    mwr_d  = (state_d == STROBE) &&  wr_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      gnt_q   <= '0;
      sel_q   <= '0;
      done_q  <= '0;
      rd_q    <= 1'b0;
      mwr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
      mwr_q   <= mwr_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.sel    = sel_q;
  assign bus.done   = done_q;
  assign bus.mem_rd = rd_q;
  assign bus.mem_wr = mwr_q;
  assign bus.busy   = (state_q != IDLE);
endmodule
